// File: rtl/axi3_pkg.sv
// Shared AXI3 definitions: burst encodings, response codes and FSM states.
package axi3_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    // Transfers wider than the 32-bit bus or using the reserved burst code are refused.
    function automatic logic bad_xfer(input logic [2:0] size, input logic [1:0] burst);
        return (size > 3'd2) || (burst == 2'b11);
    endfunction

endpackage

// File: rtl/axi3_burst_addr.sv
// Next beat address for FIXED / INCR / WRAP bursts (pure combinational).
module axi3_burst_addr
    import axi3_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [3:0]  len,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr
);

    logic [31:0] step;
    logic [31:0] wrap_mask;

    // Step by the beat size; WRAP keeps the high bits and wraps the low bits inside the burst span.
    // NOTE: every signal gets a value before the case so no path leaves it unassigned (no latch).
    always_comb begin
        step      = 32'd1 << size;
        wrap_mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
        next_addr = addr;
        case (burst_t'(burst))
            BURST_INCR: next_addr = addr + step;
            BURST_WRAP: next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
            default:    next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi3_sram_responder.sv
// AXI3 slave backed by a 2^ADDR_W x 32 word memory; independent single-outstanding
// read and write channels sharing only the memory array.
module axi3_sram_responder
    import axi3_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] mem [DEPTH];

    // Sideband fields carry no meaning for a plain memory.
    logic unused_inputs;
    assign unused_inputs = ^{awlock, awcache, awprot, arlock, arcache, arprot, wid};

    // ---------------- write channel ----------------
    wstate_t     w_state, w_next;
    logic [3:0]  w_id, w_len, w_beat;
    logic [31:0] w_addr, w_addr_nxt;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic        w_bad, w_last_err;
    logic        aw_hs, w_hs, b_hs, w_final;

    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign b_hs    = bvalid && bready;
    assign w_final = (w_beat == w_len);

    axi3_burst_addr u_w_addr (
        .addr      (w_addr),
        .size      (w_size),
        .len       (w_len),
        .burst     (w_burst),
        .next_addr (w_addr_nxt)
    );

    // Write FSM state register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    // Write FSM next state: burst length is counted, wlast is only checked.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_final) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Write channel handshake outputs and response.
    always_comb begin
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bid     = '0;
        bresp   = RESP_OKAY;
        case (w_state)
            W_IDLE: awready = 1'b1;
            W_DATA: wready  = 1'b1;
            W_RESP: begin
                bvalid = 1'b1;
                bid    = w_id;
                bresp  = (w_bad || w_last_err) ? RESP_SLVERR : RESP_OKAY;
            end
            default: ;
        endcase
    end

    // Write burst context: latched on AW, advanced per accepted beat.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            w_id       <= '0;
            w_addr     <= '0;
            w_len      <= '0;
            w_size     <= '0;
            w_burst    <= '0;
            w_beat     <= '0;
            w_bad      <= 1'b0;
            w_last_err <= 1'b0;
        end else if (aw_hs) begin
            w_id       <= awid;
            w_addr     <= awaddr;
            w_len      <= awlen;
            w_size     <= awsize;
            w_burst    <= awburst;
            w_beat     <= '0;
            w_bad      <= bad_xfer(awsize, awburst);
            w_last_err <= 1'b0;
        end else if (w_hs) begin
            w_addr <= w_addr_nxt;
            w_beat <= w_beat + 4'd1;
            if (wlast != w_final) w_last_err <= 1'b1;
        end
    end

    // Byte-masked memory write port; refused bursts leave memory untouched.
    // NOTE: the array has no reset so it maps onto RAM; contents are undefined until written.
    always_ff @(posedge aclk) begin
        if (w_hs && !w_bad) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[w_addr[ADDR_W+1:2]][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    rstate_t     r_state, r_next;
    logic [3:0]  r_id, r_len, r_beat;
    logic [31:0] r_addr, r_addr_nxt;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic        r_bad;
    logic        ar_hs, r_hs, r_final;

    assign ar_hs   = arvalid && arready;
    assign r_hs    = rvalid && rready;
    assign r_final = (r_beat == r_len);

    axi3_burst_addr u_r_addr (
        .addr      (r_addr),
        .size      (r_size),
        .len       (r_len),
        .burst     (r_burst),
        .next_addr (r_addr_nxt)
    );

    // Read FSM state register.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    // Read FSM next state: leave R_DATA once the last beat is taken.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && r_final) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read channel handshake outputs and beat attributes.
    always_comb begin
        arready = (r_state == R_IDLE);
        rvalid  = (r_state == R_DATA);
        rid     = rvalid ? r_id : '0;
        rlast   = rvalid && r_final;
        rresp   = (rvalid && r_bad) ? RESP_SLVERR : RESP_OKAY;
    end

    // Read burst context and registered read data; rdata only moves on a taken beat.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_beat  <= '0;
            r_bad   <= 1'b0;
            rdata   <= '0;
        end else if (ar_hs) begin
            r_id    <= arid;
            r_addr  <= araddr;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_beat  <= '0;
            r_bad   <= bad_xfer(arsize, arburst);
            rdata   <= bad_xfer(arsize, arburst) ? '0 : mem[araddr[ADDR_W+1:2]];
        end else if (r_hs && !r_final) begin
            r_addr <= r_addr_nxt;
            r_beat <= r_beat + 4'd1;
            rdata  <= r_bad ? '0 : mem[r_addr_nxt[ADDR_W+1:2]];
        end
    end

endmodule

// File: tb/tb_axi3_sram_responder.sv
// Randomised bench for axi3_sram_responder against a word-array reference model.
module tb_axi3_sram_responder;

    logic        aclk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  awid = '0, awlen = '0, awcache = '0, wid = '0, wstrb = '0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [2:0]  awsize = '0, awprot = '0, arsize = '0, arprot = '0;
    logic [1:0]  awburst = '0, awlock = '0, arburst = '0, arlock = '0;
    logic        awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic [3:0]  arid = '0, arlen = '0, arcache = '0;
    logic        arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rlast, rvalid;
    logic [3:0]  bid, rid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ref_mem [4096];
    logic [31:0] wbuf_data [16];
    logic [3:0]  wbuf_strb [16];

    always #5 aclk = ~aclk;

    axi3_sram_responder dut (
        .aclk(aclk), .reset(reset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Byte address of beat i, straight from the burst rules.
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [2:0] size,
                                              input logic [3:0] len, input logic [1:0] burst,
                                              input int i);
        longint step, span, base, off;
        step = longint'(1) << size;
        span = (longint'(len) + 1) * step;
        case (burst)
            2'b01: return start + 32'(longint'(i) * step);
            2'b10: begin
                base = (longint'(start) / span) * span;
                off  = longint'(start) - base;
                return 32'(base + (off + longint'(i) * step) % span);
            end
            default: return start;
        endcase
    endfunction

    function automatic bit refused(input logic [2:0] size, input logic [1:0] burst);
        return (size > 3'd2) || (burst == 2'b11);
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[a[13:2]][8*b +: 8] = d[8*b +: 8];
    endfunction

    // Full write burst from wbuf_*; bad_beat >= 0 flips wlast on that beat.
    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input int bad_beat, input bit bp);
        int  guard;
        bit  bad, done;
        logic [1:0] exp_resp;
        bad = refused(size, burst);
        exp_resp = (bad || (bad_beat >= 0 && bad_beat <= int'(len))) ? 2'b10 : 2'b00;
        @(negedge aclk);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        guard = 0;
        while (!awready && guard < 200) begin @(negedge aclk); guard++; end
        if (!awready) begin check("aw_timeout", 0, 1); awvalid = 1'b0; return; end
        @(negedge aclk);
        awvalid = 1'b0;
        check("wready_after_aw", wready, 1);
        check("awready_busy", awready, 0);
        for (int i = 0; i <= int'(len); i++) begin
            if (bp) while ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(negedge aclk); end
            wvalid = 1'b1; wdata = wbuf_data[i]; wstrb = wbuf_strb[i]; wid = ~id;
            wlast  = (i == int'(len)) ^ (i == bad_beat);
            guard = 0;
            while (!wready && guard < 200) begin @(negedge aclk); guard++; end
            if (!wready) begin check("w_timeout", 0, 1); wvalid = 1'b0; return; end
            if (!bad) model_write(beat_addr(addr, size, len, burst, i), wbuf_data[i], wbuf_strb[i]);
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("bvalid_after_last_w", bvalid, 1);
        guard = 0; done = 1'b0;
        while (!done && guard < 200) begin
            bready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bvalid && bready) begin
                check("b_id", bid, id);
                check("b_resp", bresp, exp_resp);
                done = 1'b1;
            end
            @(negedge aclk); guard++;
        end
        bready = 1'b0;
        if (!done) check("b_timeout", 0, 1);
        else       check("awready_after_b", awready, 1);
    endtask

    // Full read burst checked beat by beat, including stability under back-pressure.
    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input bit bp);
        int  guard, beat;
        bit  bad, stalled;
        logic [31:0] held_d, a;
        logic held_l;
        bad = refused(size, burst);
        @(negedge aclk);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        guard = 0;
        while (!arready && guard < 200) begin @(negedge aclk); guard++; end
        if (!arready) begin check("ar_timeout", 0, 1); arvalid = 1'b0; return; end
        @(negedge aclk);
        arvalid = 1'b0;
        check("rvalid_after_ar", rvalid, 1);
        check("arready_busy", arready, 0);
        beat = 0; stalled = 1'b0; guard = 0; held_d = '0; held_l = 1'b0;
        while (beat <= int'(len) && guard < 1000) begin
            if (rvalid && stalled) begin
                check("r_hold_data", rdata, held_d);
                check("r_hold_last", rlast, held_l);
            end
            rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rvalid && rready) begin
                a = beat_addr(addr, size, len, burst, beat);
                check("r_data", rdata, bad ? 32'd0 : ref_mem[a[13:2]]);
                check("r_resp", rresp, bad ? 2'b10 : 2'b00);
                check("r_id", rid, id);
                check("r_last", rlast, beat == int'(len));
                beat++; stalled = 1'b0;
            end else if (rvalid) begin
                stalled = 1'b1; held_d = rdata; held_l = rlast;
            end
            @(negedge aclk); guard++;
        end
        rready = 1'b0;
        if (beat <= int'(len)) check("r_timeout", 0, 1);
        else                   check("arready_after_last_r", arready, 1);
    endtask

    // Random legal (mostly) burst inside one 8 KiB half of the aliased 16 KiB window.
    task automatic pick_burst(input bit hi_half, output logic [31:0] addr, output logic [3:0] len,
                              output logic [2:0] size, output logic [1:0] burst);
        logic [31:0] r;
        logic [12:0] off;
        burst = 2'($urandom_range(0, 2));
        size  = 3'($urandom_range(0, 2));
        len   = 4'($urandom_range(0, 15));
        if (burst == 2'b10) begin
            case ($urandom_range(0, 3))
                0: len = 4'd1;
                1: len = 4'd3;
                2: len = 4'd7;
                default: len = 4'd15;
            endcase
        end
        if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 0) size = 3'($urandom_range(3, 7));
            else                           burst = 2'b11;
        end
        off = 13'($urandom_range(0, 13'h1F00));
        if (size <= 3'd2) off = off & ~13'((1 << size) - 1);
        r = $urandom;
        addr = {r[31:14], hi_half, off};
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  l;
        logic [2:0]  s;
        logic [1:0]  bu;
        int bb;

        // Reset values while reset is held.
        repeat (3) @(negedge aclk);
        check("rst_awready", awready, 1);
        check("rst_arready", arready, 1);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_ids", {bid, rid}, 0);
        check("rst_resps", {bresp, rresp}, 0);
        check("rst_rdata", rdata, 0);
        reset = 1'b0;

        // Fill the whole memory so every later read has a known value.
        for (int blk = 0; blk < 256; blk++) begin
            for (int i = 0; i < 16; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = 4'hF; end
            write_burst(4'(blk), 32'(blk * 64), 4'd15, 3'd2, 2'b01, -1, 1'b0);
        end

        // INCR write/readback at 0x100, then WRAP from 0x108 and an aliased read.
        for (int i = 0; i < 4; i++) begin wbuf_data[i] = 32'hA0 + 32'(i); wbuf_strb[i] = 4'hF; end
        write_burst(4'h7, 32'h100, 4'd3, 3'd2, 2'b01, -1, 1'b0);
        read_burst(4'h9, 32'h100, 4'd3, 3'd2, 2'b01, 1'b0);
        read_burst(4'h3, 32'h108, 4'd3, 3'd2, 2'b10, 1'b0);
        read_burst(4'hC, 32'hFFFF_C100, 4'd3, 3'd2, 2'b01, 1'b0);

        // Narrow byte write into a known word.
        wbuf_data[0] = 32'h1122_3344; wbuf_strb[0] = 4'hF;
        write_burst(4'h1, 32'h200, 4'd0, 3'd2, 2'b01, -1, 1'b0);
        wbuf_data[0] = 32'h0000_5500; wbuf_strb[0] = 4'b0010;
        write_burst(4'h2, 32'h201, 4'd0, 3'd0, 2'b01, -1, 1'b0);
        read_burst(4'h4, 32'h200, 4'd0, 3'd2, 2'b01, 1'b0);

        // Early wlast: data lands, response is SLVERR.
        for (int i = 0; i < 4; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = 4'hF; end
        write_burst(4'h5, 32'h140, 4'd3, 3'd2, 2'b01, 1, 1'b0);
        read_burst(4'h6, 32'h140, 4'd3, 3'd2, 2'b01, 1'b0);

        // Refused transfers: oversize write leaves memory, reserved-burst read returns zeros.
        for (int i = 0; i < 2; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = 4'hF; end
        write_burst(4'hA, 32'h180, 4'd1, 3'd3, 2'b01, -1, 1'b0);
        read_burst(4'hB, 32'h180, 4'd1, 3'd2, 2'b01, 1'b0);
        read_burst(4'hD, 32'h100, 4'd1, 3'd2, 2'b11, 1'b0);

        // Concurrent random bursts with back-pressure on disjoint halves.
        for (int it = 0; it < 24; it++) begin
            logic [31:0] wa, ra;
            logic [3:0]  wl, rl, wi, ri;
            logic [2:0]  ws, rs;
            logic [1:0]  wb, rb;
            pick_burst(1'b1, wa, wl, ws, wb);
            pick_burst(1'b0, ra, rl, rs, rb);
            wi = 4'($urandom); ri = 4'($urandom);
            bb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : -1;
            for (int i = 0; i < 16; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = 4'($urandom); end
            fork
                write_burst(wi, wa, wl, ws, wb, bb, 1'b1);
                read_burst(ri, ra, rl, rs, rb, 1'b1);
            join
        end
        for (int it = 0; it < 8; it++) begin
            pick_burst(1'b1, a, l, s, bu);
            read_burst(4'($urandom), a, l, s, bu, 1'b1);
        end

        // Reset while beat 2 of an 8-beat read is on the bus.
        @(negedge aclk);
        arid = 4'h8; araddr = 32'h300; arlen = 4'd7; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        check("rstmid_arready", arready, 1);
        @(negedge aclk);
        arvalid = 1'b0; rready = 1'b1;
        repeat (2) @(negedge aclk);
        check("rstmid_beat2_valid", rvalid, 1);
        check("rstmid_beat2_data", rdata, ref_mem[12'h0C2]);
        reset = 1'b1;
        #1;
        check("rstmid_rvalid", rvalid, 0);
        check("rstmid_arready_now", arready, 1);
        check("rstmid_rdata", rdata, 0);
        rready = 1'b0;
        @(negedge aclk);
        reset = 1'b0;
        read_burst(4'h8, 32'h300, 4'd7, 3'd2, 2'b01, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
